// File: rtl/qdec_bin_engine_pkg.sv
// CABAC engine shared types and tables: FSM states, LPS range table, LPS state transitions.
// Pure constants and one combinational helper; no timing or flow control here.
package qdec_cabac_package;

   typedef enum logic [2:0] {HALT, INIT, IDLE, CTX_RD, CALC} t_state_bin;

   localparam logic [7:0] RANGE_TAB_LPS [64][4] = '{
      '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
      '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
      '{ 95,116,137,158}, '{ 90,110,130,150}, '{ 85,104,123,142}, '{ 81, 99,117,135},
      '{ 77, 94,111,128}, '{ 73, 89,105,122}, '{ 69, 85,100,116}, '{ 66, 80, 95,110},
      '{ 62, 76, 90,104}, '{ 59, 72, 86, 99}, '{ 56, 69, 81, 94}, '{ 53, 65, 77, 89},
      '{ 51, 62, 73, 85}, '{ 48, 59, 69, 80}, '{ 46, 56, 66, 76}, '{ 43, 53, 63, 72},
      '{ 41, 50, 59, 69}, '{ 39, 48, 56, 65}, '{ 37, 45, 54, 62}, '{ 35, 43, 51, 59},
      '{ 33, 41, 48, 56}, '{ 32, 39, 46, 53}, '{ 30, 37, 43, 50}, '{ 29, 35, 41, 48},
      '{ 27, 33, 39, 45}, '{ 26, 31, 37, 43}, '{ 24, 30, 35, 41}, '{ 23, 28, 33, 39},
      '{ 22, 27, 32, 37}, '{ 21, 26, 30, 35}, '{ 20, 24, 29, 33}, '{ 19, 23, 27, 31},
      '{ 18, 22, 26, 30}, '{ 17, 21, 25, 28}, '{ 16, 20, 23, 27}, '{ 15, 19, 22, 25},
      '{ 14, 18, 21, 24}, '{ 14, 17, 20, 23}, '{ 13, 16, 19, 22}, '{ 12, 15, 18, 21},
      '{ 12, 14, 17, 20}, '{ 11, 14, 16, 19}, '{ 11, 13, 15, 18}, '{ 10, 12, 15, 17},
      '{ 10, 12, 14, 16}, '{  9, 11, 13, 15}, '{  9, 11, 12, 14}, '{  8, 10, 12, 14},
      '{  8,  9, 11, 13}, '{  7,  9, 11, 12}, '{  7,  9, 10, 12}, '{  7,  8, 10, 11},
      '{  6,  8,  9, 11}, '{  6,  7,  9, 10}, '{  6,  7,  8,  9}, '{  2,  2,  2,  2}
   };

   localparam logic [5:0] TRANS_IDX_LPS [64] = '{
       0,  0,  1,  2,  2,  4,  4,  5,  6,  7,  8,  9,  9, 11, 11, 12,
      13, 13, 15, 15, 16, 16, 18, 18, 19, 19, 21, 21, 22, 22, 23, 24,
      24, 25, 26, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 32, 32, 33,
      33, 33, 34, 34, 35, 35, 35, 36, 36, 36, 37, 37, 37, 38, 38, 63
   };

   function automatic logic [3:0] lead_zeros(input logic [8:0] r);
      logic [3:0] n;
      logic       found;
      n     = 4'd9;
      found = 1'b0;
      for (int i = 8; i >= 0; i--) begin
         if (!found && r[i]) begin
            n     = 4'(8 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/qdec_bitbuf.sv
// MSB-first bit buffer: bytes in, 0..9 bits consumed per cycle; peek is combinational, consume registered.
// Takes a byte only while at least 8 bits are free; flush empties it but still keeps a byte taken that cycle.
module qdec_bitbuf #(
   parameter int BUF_W = 16,
   parameter int CW    = $clog2(BUF_W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [7:0]    bs_data,
   input  logic          bs_vld,
   output logic          bs_rd,
   input  logic [3:0]    consume,
   output logic [8:0]    peek,
   output logic [CW-1:0] count
);

   logic [BUF_W-1:0] bits_q;
   logic [BUF_W-1:0] kept;
   logic [BUF_W-1:0] byte_al;
   logic [CW-1:0]    kept_cnt;

   assign bs_rd = bs_vld && (count <= CW'(BUF_W - 8));
   assign peek  = bits_q[BUF_W-1 -: 9];

   // Valid bits sit at the top; everything below count is kept zero so OR-append is safe.
   always_comb begin
      kept     = '0;
      kept_cnt = '0;
      if (!flush) begin
         kept     = bits_q << consume;
         kept_cnt = count - CW'(consume);
      end
      byte_al = {bs_data, {(BUF_W-8){1'b0}}} >> kept_cnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bits_q <= '0;
         count  <= '0;
      end else if (bs_rd) begin
         bits_q <= kept | byte_al;
         count  <= kept_cnt + CW'(8);
      end else begin
         bits_q <= kept;
         count  <= kept_cnt;
      end
   end

endmodule

// File: rtl/qdec_bin_engine.sv
// CABAC binary arithmetic decoder: bypass/terminate bins in 1 cycle, regular bins in 2 (ctx read, then update).
// dec_rdy drops from acceptance through the ruiBin_vld cycle; requests while not ready are dropped.
module qdec_bin_engine
   import qdec_cabac_package::*;
#(
   parameter int CTX_AW = 10,
   parameter int BUF_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              engine_init,
   input  logic [CTX_AW-1:0] ctx_addr,
   input  logic              ctx_addr_vld,
   input  logic              dec_run,
   input  logic              EPMode,
   input  logic              term_mode,
   output logic              dec_rdy,
   output logic              ruiBin,
   output logic              ruiBin_vld,
   output logic [CTX_AW-1:0] ctx_rd_addr,
   input  logic [6:0]        ctx_rd_data,
   output logic              ctx_wr_en,
   output logic [CTX_AW-1:0] ctx_wr_addr,
   output logic [6:0]        ctx_wr_data,
   input  logic [7:0]        bs_data,
   input  logic              bs_vld,
   output logic              bs_rd,
   output logic              term_hit
);

   localparam int CW = $clog2(BUF_W + 1);

   t_state_bin        state_q, state_d;
   logic [8:0]        range_q, range_d, offset_q, offset_d;
   logic [6:0]        ctx_q;
   logic [CTX_AW-1:0] ctx_addr_q;
   logic              bin_q, bin_d, bin_vld_q, bin_vld_d, term_hit_q, term_hit_d;
   logic [3:0]        consume;
   logic [8:0]        peek;
   logic [CW-1:0]     count;
   logic              ready, accept, is_regular, calc_vld;

   logic [5:0]        p_state, p_next;
   logic              val_mps, mps_next, reg_bin;
   logic [8:0]        r_lps, r_mps, rng_a, off_a, reg_off;
   logic [3:0]        reg_shift;
   logic [9:0]        byp_off;
   logic [8:0]        term_rng;

   qdec_bitbuf #(.BUF_W(BUF_W), .CW(CW)) u_bitbuf (
      .clk     (clk),
      .rst     (rst),
      .flush   (engine_init),
      .bs_data (bs_data),
      .bs_vld  (bs_vld),
      .bs_rd   (bs_rd),
      .consume (consume),
      .peek    (peek),
      .count   (count)
   );

   assign ready      = (state_q == IDLE) && (count >= CW'(8)) && !bin_vld_q;
   assign is_regular = !term_mode && !EPMode;
   assign accept     = ready && dec_run && !engine_init && (!is_regular || ctx_addr_vld);
   // A restart landing on the CALC cycle kills the regular bin before it is reported or written back.
   assign calc_vld   = (state_q == CALC) && !engine_init;

   always_comb begin : regular_path
      p_state  = ctx_q[6:1];
      val_mps  = ctx_q[0];
      r_lps    = {1'b0, RANGE_TAB_LPS[p_state][range_q[7:6]]};
      r_mps    = range_q - r_lps;
      reg_bin  = val_mps;
      off_a    = offset_q;
      rng_a    = r_mps;
      mps_next = val_mps;
      p_next   = (p_state >= 6'd62) ? 6'd62 : p_state + 6'd1;
      if (offset_q >= r_mps) begin
         reg_bin  = !val_mps;
         off_a    = offset_q - r_mps;
         rng_a    = r_lps;
         mps_next = (p_state == 6'd0) ? !val_mps : val_mps;
         p_next   = TRANS_IDX_LPS[p_state];
      end
      reg_shift = lead_zeros(rng_a);
      reg_off   = 9'(({off_a, peek} << reg_shift) >> 9);
   end

   always_comb begin : fsm
      state_d    = state_q;
      range_d    = range_q;
      offset_d   = offset_q;
      consume    = 4'd0;
      bin_d      = 1'b0;
      bin_vld_d  = 1'b0;
      term_hit_d = 1'b0;
      byp_off    = {offset_q, peek[8]};
      term_rng   = range_q - 9'd2;
      if (engine_init) begin
         state_d = INIT;
      end else begin
         case (state_q)
            HALT: state_d = HALT;
            INIT: begin
               if (count >= CW'(9)) begin
                  offset_d = peek;
                  range_d  = 9'd510;
                  consume  = 4'd9;
                  state_d  = IDLE;
               end
            end
            IDLE: begin
               if (accept) begin
                  if (term_mode) begin
                     bin_vld_d = 1'b1;
                     range_d   = term_rng;
                     if (offset_q >= term_rng) begin
                        bin_d      = 1'b1;
                        term_hit_d = 1'b1;
                        state_d    = HALT;
                     end else if (!term_rng[8]) begin
                        range_d  = term_rng << 1;
                        offset_d = {offset_q[7:0], peek[8]};
                        consume  = 4'd1;
                     end
                  end else if (EPMode) begin
                     bin_vld_d = 1'b1;
                     consume   = 4'd1;
                     offset_d  = byp_off[8:0];
                     if (byp_off >= {1'b0, range_q}) begin
                        bin_d    = 1'b1;
                        offset_d = 9'(byp_off - {1'b0, range_q});
                     end
                  end else begin
                     state_d = CTX_RD;
                  end
               end
            end
            CTX_RD: state_d = CALC;
            CALC: begin
               range_d  = rng_a << reg_shift;
               offset_d = reg_off;
               consume  = reg_shift;
               state_d  = IDLE;
            end
            default: state_d = HALT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HALT;
         range_q    <= 9'd510;
         offset_q   <= 9'd0;
         ctx_q      <= 7'd0;
         ctx_addr_q <= '0;
         bin_q      <= 1'b0;
         bin_vld_q  <= 1'b0;
         term_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         range_q    <= range_d;
         offset_q   <= offset_d;
         bin_q      <= bin_d;
         bin_vld_q  <= bin_vld_d;
         term_hit_q <= term_hit_d;
         if (accept && is_regular) ctx_addr_q <= ctx_addr;
         if (state_q == CTX_RD) ctx_q <= ctx_rd_data;
      end
   end

   assign dec_rdy     = ready;
   assign ruiBin_vld  = bin_vld_q | calc_vld;
   assign ruiBin      = calc_vld ? reg_bin : bin_q;
   assign term_hit    = term_hit_q;
   assign ctx_rd_addr = (accept && is_regular) ? ctx_addr : '0;
   assign ctx_wr_en   = calc_vld;
   assign ctx_wr_addr = calc_vld ? ctx_addr_q : '0;
   assign ctx_wr_data = calc_vld ? {p_next, mps_next} : 7'd0;

endmodule

// File: tb/tb_qdec_bin_engine.sv
// Directed bench for qdec_bin_engine with a sync context RAM model and a byte-queue bitstream source.
module tb_qdec_bin_engine;

   logic       clk;
   logic       rst;
   logic       engine_init;
   logic [9:0] ctx_addr;
   logic       ctx_addr_vld;
   logic       dec_run;
   logic       EPMode;
   logic       term_mode;
   logic       dec_rdy;
   logic       ruiBin;
   logic       ruiBin_vld;
   logic [9:0] ctx_rd_addr;
   logic [6:0] ctx_rd_data;
   logic       ctx_wr_en;
   logic [9:0] ctx_wr_addr;
   logic [6:0] ctx_wr_data;
   logic [7:0] bs_data;
   logic       bs_vld;
   logic       bs_rd;
   logic       term_hit;

   int         checks = 0;
   int         failures = 0;
   logic [6:0] ctx_mem [1024];
   logic [7:0] bq [$];

   qdec_bin_engine dut (
      .clk          (clk),
      .rst          (rst),
      .engine_init  (engine_init),
      .ctx_addr     (ctx_addr),
      .ctx_addr_vld (ctx_addr_vld),
      .dec_run      (dec_run),
      .EPMode       (EPMode),
      .term_mode    (term_mode),
      .dec_rdy      (dec_rdy),
      .ruiBin       (ruiBin),
      .ruiBin_vld   (ruiBin_vld),
      .ctx_rd_addr  (ctx_rd_addr),
      .ctx_rd_data  (ctx_rd_data),
      .ctx_wr_en    (ctx_wr_en),
      .ctx_wr_addr  (ctx_wr_addr),
      .ctx_wr_data  (ctx_wr_data),
      .bs_data      (bs_data),
      .bs_vld       (bs_vld),
      .bs_rd        (bs_rd),
      .term_hit     (term_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive_bs();
      bs_vld  = (bq.size() > 0);
      bs_data = bs_vld ? bq[0] : 8'h00;
   endtask

   // One clock: sample handshakes at the edge, then update RAM and byte source 1 time unit later.
   task automatic tick();
      logic       xfer;
      logic       we;
      logic [9:0] ra;
      logic [9:0] wa;
      logic [6:0] wd;
      @(posedge clk);
      xfer = bs_vld && bs_rd;
      ra   = ctx_rd_addr;
      we   = ctx_wr_en;
      wa   = ctx_wr_addr;
      wd   = ctx_wr_data;
      #1;
      if (xfer) void'(bq.pop_front());
      if (we) ctx_mem[wa] = wd;
      ctx_rd_data = ctx_mem[ra];
      drive_bs();
   endtask

   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      while (!dec_rdy && n < 40) begin
         tick();
         n++;
      end
      check(tag, dec_rdy, 1);
   endtask

   task automatic start_stream(input logic [7:0] b0, input logic [7:0] b1);
      bq.delete();
      bq.push_back(b0);
      bq.push_back(b1);
      bq.push_back(8'h00);
      bq.push_back(8'h00);
      drive_bs();
      engine_init = 1'b1;
      tick();
      engine_init = 1'b0;
   endtask

   task automatic req(input logic ep, input logic tm, input logic [9:0] a);
      EPMode       = ep;
      term_mode    = tm;
      ctx_addr     = a;
      ctx_addr_vld = !(ep || tm);
      dec_run      = 1'b1;
   endtask

   task automatic idle_req();
      dec_run      = 1'b0;
      EPMode       = 1'b0;
      term_mode    = 1'b0;
      ctx_addr_vld = 1'b0;
   endtask

   initial begin
      rst = 1'b1; engine_init = 1'b0; ctx_addr = '0; ctx_rd_data = '0;
      bs_data = '0; bs_vld = 1'b0;
      idle_req();
      for (int i = 0; i < 1024; i++) ctx_mem[i] = 7'd0;
      ctx_mem[20] = 7'd124;
      repeat (3) tick();
      check("rst_rdy", dec_rdy, 0);
      check("rst_vld", ruiBin_vld, 0);
      check("rst_wr", ctx_wr_en, 0);
      check("rst_term", term_hit, 0);
      check("rst_bsrd", bs_rd, 0);
      check("rst_range", dut.range_q, 510);
      rst = 1'b0;
      tick();

      // Init from 0x80 0x00, then starve with 7 bits buffered
      bq.delete();
      bq.push_back(8'h80);
      bq.push_back(8'h00);
      drive_bs();
      engine_init = 1'b1;
      tick();
      engine_init = 1'b0;
      tick();
      tick();
      check("init_offset", dut.offset_q, 256);
      check("init_range", dut.range_q, 510);
      check("starve_rdy0", dec_rdy, 0);
      repeat (3) tick();
      check("starve_rdy1", dec_rdy, 0);
      check("starve_offset", dut.offset_q, 256);
      bq.push_back(8'h00);
      bq.push_back(8'h00);
      bq.push_back(8'h00);
      drive_bs();
      #1;
      check("starve_bsrd", bs_rd, 1);
      tick();
      check("resume_rdy", dec_rdy, 1);

      // Bypass: 512 >= 510 -> bin 1, offset 2
      check("byp_vld_c0", ruiBin_vld, 0);
      req(1'b1, 1'b0, 10'd0);
      tick();
      idle_req();
      check("byp_vld", ruiBin_vld, 1);
      check("byp_bin", ruiBin, 1);
      check("byp_rdy_c1", dec_rdy, 0);
      check("byp_offset", dut.offset_q, 2);
      tick();
      check("byp_vld_c2", ruiBin_vld, 0);
      check("byp_rdy_c2", dec_rdy, 1);

      // Regular MPS on ctx 5 = {0,0}
      req(1'b0, 1'b0, 10'd5);
      #1;
      check("mps_rd_addr", ctx_rd_addr, 5);
      tick();
      idle_req();
      check("mps_vld_c1", ruiBin_vld, 0);
      check("mps_wr_c1", ctx_wr_en, 0);
      check("mps_rdy_c1", dec_rdy, 0);
      tick();
      check("mps_vld", ruiBin_vld, 1);
      check("mps_bin", ruiBin, 0);
      check("mps_wr_en", ctx_wr_en, 1);
      check("mps_wr_addr", ctx_wr_addr, 5);
      check("mps_wr_data", ctx_wr_data, 7'h02);
      check("mps_rdy_c2", dec_rdy, 0);
      tick();
      check("mps_vld_c3", ruiBin_vld, 0);
      check("mps_rdy_c3", dec_rdy, 1);
      check("mps_range", dut.range_q, 270);
      check("mps_offset", dut.offset_q, 2);

      // Bypass with bin 0: 4 < 270
      req(1'b1, 1'b0, 10'd0);
      tick();
      idle_req();
      check("byp0_bin", ruiBin, 0);
      check("byp0_vld", ruiBin_vld, 1);
      check("byp0_offset", dut.offset_q, 4);
      tick();

      // Regular LPS: offset 300, ctx 9 = {0,0}; renorm by 1 pulls bit 1
      start_stream(8'h96, 8'h40);
      wait_rdy("lps_init_rdy");
      check("lps_init_offset", dut.offset_q, 300);
      req(1'b0, 1'b0, 10'd9);
      tick();
      idle_req();
      tick();
      check("lps_vld", ruiBin_vld, 1);
      check("lps_bin", ruiBin, 1);
      check("lps_wr_addr", ctx_wr_addr, 9);
      check("lps_wr_data", ctx_wr_data, 7'h01);
      tick();
      check("lps_range", dut.range_q, 480);
      check("lps_offset", dut.offset_q, 61);

      // Terminate, not hit: range 478, no renorm
      req(1'b0, 1'b1, 10'd0);
      tick();
      idle_req();
      check("term0_vld", ruiBin_vld, 1);
      check("term0_bin", ruiBin, 0);
      check("term0_hit", term_hit, 0);
      check("term0_range", dut.range_q, 478);
      tick();

      // pState 62 MPS saturates at 62
      req(1'b0, 1'b0, 10'd20);
      tick();
      idle_req();
      tick();
      check("sat_bin", ruiBin, 0);
      check("sat_wr_data", ctx_wr_data, 7'd124);
      tick();
      check("sat_range", dut.range_q, 469);
      check("sat_offset", dut.offset_q, 61);

      // Terminate hit: offset 508, range 510
      start_stream(8'hFE, 8'h00);
      wait_rdy("term_init_rdy");
      check("term_init_offset", dut.offset_q, 508);
      req(1'b0, 1'b1, 10'd0);
      tick();
      idle_req();
      check("term1_vld", ruiBin_vld, 1);
      check("term1_bin", ruiBin, 1);
      check("term1_hit", term_hit, 1);
      tick();
      check("term1_hit_c2", term_hit, 0);
      repeat (3) tick();
      check("halt_rdy", dec_rdy, 0);

      // Reset during cycle 1 of a regular bin
      start_stream(8'h80, 8'h00);
      wait_rdy("abort_init_rdy");
      req(1'b0, 1'b0, 10'd5);
      tick();
      idle_req();
      rst = 1'b1;
      #1;
      check("abort_vld_c1", ruiBin_vld, 0);
      tick();
      check("abort_vld_c2", ruiBin_vld, 0);
      check("abort_wr_c2", ctx_wr_en, 0);
      rst = 1'b0;
      tick();
      check("abort_rdy", dec_rdy, 0);
      check("abort_range", dut.range_q, 510);
      check("abort_mem", ctx_mem[5], 7'h02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
